load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_byte_lane.sv | 25 ++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit.
package lsu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        ERROR
    } lsu_state_e;

    // Latched request attributes; address is the full byte address (word index + lane).
    typedef struct packed {
        logic            store;
        logic            is_byte;
        logic            sext;
        logic [ADDR_W:0] addr;
    } lsu_req_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane extract/extend for loads and lane merge for byte stores.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              lane_i,
    input  logic              is_byte_i,
    input  logic              sext_i,
    input  logic [BYTE_W-1:0] wbyte_i,
    output logic [DATA_W-1:0] load_data_o,
    output logic [DATA_W-1:0] merged_o
);

    logic [BYTE_W-1:0] lane_byte;
    logic              fill;

    always_comb begin
        lane_byte   = lane_i ? rdata_i[DATA_W-1:BYTE_W] : rdata_i[BYTE_W-1:0];
        fill        = sext_i & lane_byte[BYTE_W-1];
        load_data_o = is_byte_i ? {{(DATA_W-BYTE_W){fill}}, lane_byte} : rdata_i;
        merged_o    = lane_i ? {wbyte_i, rdata_i[BYTE_W-1:0]}
                             : {rdata_i[DATA_W-1:BYTE_W], wbyte_i};
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with byte read-modify-write and global stall.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              suspend_cpu,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] data_memory_address,
    output logic [DATA_W-1:0] data_memory_write,
    output logic              data_memory_write_en,
    output logic              data_memory_read_en,
    input  logic [DATA_W-1:0] data_memory_read
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] load_data, merged;

    lsu_byte_lane u_lane (
        .rdata_i    (data_memory_read),
        .lane_i     (req_q.addr[0]),
        .is_byte_i  (req_q.is_byte),
        .sext_i     (req_q.sext),
        .wbyte_i    (wdata_q[BYTE_W-1:0]),
        .load_data_o(load_data),
        .merged_o   (merged)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and register updates; a stalled edge leaves everything as it was.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        wdata_d      = wdata_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        if (suspend_cpu) begin
            resp_valid_d = resp_valid_q;
            resp_err_d   = resp_err_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_d   = '{store: req_store, is_byte: req_byte,
                                    sext: req_signed, addr: req_addr};
                        wdata_d = req_wdata;
                        if (!req_byte && req_addr[0])  state_d = ERROR;
                        else if (req_store && !req_byte) state_d = WRITE;
                        else                           state_d = READ;
                    end
                end
                READ: state_d = CAPTURE;
                CAPTURE: begin
                    if (req_q.store) begin
                        wdata_d = merged;
                        state_d = WRITE;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = load_data;
                        state_d      = IDLE;
                    end
                end
                WRITE: begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    state_d      = IDLE;
                end
                ERROR: begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        rd_en_d = (state_d == READ);
        wr_en_d = (state_d == WRITE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q        <= '0;
            wdata_q      <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            req_q        <= req_d;
            wdata_q      <= wdata_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            ready_q      <= ready_d;
        end
    end

    assign req_ready            = ready_q;
    assign resp_valid           = resp_valid_q;
    assign resp_err             = resp_err_q;
    assign resp_data            = resp_data_q;
    assign data_memory_address  = req_q.addr[ADDR_W:1];
    assign data_memory_write    = wdata_q;
    assign data_memory_read_en  = rd_en_q;
    assign data_memory_write_en = wr_en_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a word-array reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        suspend_cpu = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic [7:0]  data_memory_address;
    logic [15:0] data_memory_write;
    logic        data_memory_write_en;
    logic        data_memory_read_en;
    logic [15:0] data_memory_read;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    int n_checks = 0;
    int n_pass = 0;
    int both_en = 0;
    int rv_count = 0;
    bit en_seen = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk                 (clk),
        .rstn                (rstn),
        .suspend_cpu         (suspend_cpu),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_store           (req_store),
        .req_byte            (req_byte),
        .req_signed          (req_signed),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .resp_valid          (resp_valid),
        .resp_data           (resp_data),
        .resp_err            (resp_err),
        .data_memory_address (data_memory_address),
        .data_memory_write   (data_memory_write),
        .data_memory_write_en(data_memory_write_en),
        .data_memory_read_en (data_memory_read_en),
        .data_memory_read    (data_memory_read)
    );

    // Synchronous memory with one-edge read latency and a preload port.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (data_memory_write_en) mem[data_memory_address] <= data_memory_write;
        if (data_memory_read_en) data_memory_read <= mem[data_memory_address];
    end

    always @(negedge clk) begin
        if (data_memory_read_en && data_memory_write_en) both_en++;
        if (data_memory_read_en || data_memory_write_en) en_seen = 1;
        if (resp_valid) rv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_load(input logic [8:0] addr, input bit byt, input bit sgn);
        int w, b;
        w = int'(ref_mem[addr / 2]);
        if (!byt) return 16'(w);
        b = (addr % 2 == 1) ? (w / 256) : (w % 256);
        if (sgn && b >= 128) b = b + 'hFF00;
        return 16'(b);
    endfunction

    task automatic poke(input int idx, input logic [15:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 8'(idx); pl_data = v;
        ref_mem[idx] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // mode: 0 no stall, 1 random stalls, 2 three stalled edges while in CAPTURE
    task automatic access(input bit st, input bit byt, input bit sgn, input logic [8:0] addr,
                          input logic [15:0] wd, input int mode);
        logic [15:0] exp_data;
        logic [1:0]  exp_en;
        int base, susp, cyc, idx, w;
        bit err, done;
        err = !byt && addr[0];
        idx = int'(addr / 2);
        if (err)            begin base = 1; exp_en = 2'b00; end
        else if (st && !byt) begin base = 1; exp_en = 2'b01; end
        else                begin base = st ? 3 : 2; exp_en = 2'b10; end
        exp_data = (err || st) ? 16'h0 : ref_load(addr, byt, sgn);
        susp = 0; cyc = 0; done = 0;
        @(negedge clk);
        check("ready_before_accept", 32'(req_ready), 1);
        req_valid = 1'b1; req_store = st; req_byte = byt; req_signed = sgn;
        req_addr = addr; req_wdata = wd; suspend_cpu = 1'b0;
        en_seen = 0;
        @(posedge clk); #1;
        req_valid = $urandom_range(0, 1) == 1;
        req_store = 1'($urandom); req_byte = 1'($urandom); req_signed = 1'($urandom);
        req_addr = 9'($urandom); req_wdata = 16'($urandom);
        check("enables_after_accept", 32'({data_memory_read_en, data_memory_write_en}), 32'(exp_en));
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (mode == 1)      suspend_cpu = $urandom_range(0, 3) == 0;
            else if (mode == 2) suspend_cpu = (k >= 1 && k <= 3);
            else                suspend_cpu = 1'b0;
            if (suspend_cpu) susp++;
            @(posedge clk); #1;
            cyc++;
            if (resp_valid) done = 1;
        end
        suspend_cpu = 1'b0; req_valid = 1'b0;
        check("resp_seen", 32'(done), 1);
        check("latency", 32'(cyc), 32'(base + susp));
        check("resp_err", 32'(resp_err), 32'(err));
        check("resp_data", 32'(resp_data), 32'(exp_data));
        if (err) check("error_no_enable", 32'(en_seen), 0);
        if (st && !err) begin
            w = int'(ref_mem[idx]);
            if (!byt)              w = int'(wd);
            else if (addr[0])      w = (w % 256) + int'(wd[7:0]) * 256;
            else                   w = (w / 256) * 256 + int'(wd[7:0]);
            ref_mem[idx] = 16'(w);
            check("mem_after_store", 32'(mem[idx]), 32'(ref_mem[idx]));
        end
    endtask

    initial begin
        int rc;
        bit st, byt;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 8'(i); pl_data = 16'($urandom);
            ref_mem[i] = pl_data;
        end
        @(negedge clk); pl_en = 1'b0;
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_enables", 32'({data_memory_read_en, data_memory_write_en}), 0);
        check("rst_resp_data", 32'(resp_data), 0);
        check("rst_mem_addr", 32'(data_memory_address), 0);
        check("rst_mem_wdata", 32'(data_memory_write), 0);
        check("rst_ready", 32'(req_ready), 1);
        rstn = 1'b1;

        // Directed scenarios
        poke(8'h08, 16'hBEEF);
        access(0, 0, 0, 9'h010, 16'h0, 0);
        check("word_load_beef", 32'(resp_data), 32'h0000BEEF);
        poke(8'h08, 16'h80FF);
        access(0, 1, 1, 9'h011, 16'h0, 0);
        check("byte_load_signed", 32'(resp_data), 32'h0000FF80);
        access(0, 1, 0, 9'h011, 16'h0, 0);
        check("byte_load_unsigned", 32'(resp_data), 32'h00000080);
        access(0, 0, 0, 9'h003, 16'h0, 0);
        check("misaligned_err", 32'({resp_valid, resp_err}), 32'h3);

        poke(8'h08, 16'hBEEF);
        access(0, 0, 0, 9'h010, 16'h0, 2);
        check("stalled_load_data", 32'(resp_data), 32'h0000BEEF);
        @(negedge clk); suspend_cpu = 1'b1;
        @(posedge clk); #1;
        check("pending_resp_held", 32'(resp_valid), 1);
        @(negedge clk); suspend_cpu = 1'b0;
        @(posedge clk); #1;
        check("resp_drops_after_unstalled", 32'(resp_valid), 0);

        // Reset in the middle of a byte-store read phase
        poke(8'h10, 16'h1234);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
        req_addr = 9'h021; req_wdata = 16'h005A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_test_read_en", 32'(data_memory_read_en), 1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_enables", 32'({data_memory_read_en, data_memory_write_en}), 0);
        check("async_rst_ready", 32'(req_ready), 1);
        rc = rv_count;
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resp_after_rst", 32'(rv_count - rc), 0);
        check("mem_untouched_by_rst", 32'(mem[8'h10]), 32'h1234);
        check("ready_after_rst", 32'(req_ready), 1);

        access(1, 1, 0, 9'h021, 16'h005A, 0);
        check("byte_store_merge", 32'(mem[8'h10]), 32'h5A34);

        // Randomized traffic over a small address window to force reuse
        for (int n = 0; n < 80; n++) begin
            st  = $urandom_range(0, 1) == 1;
            byt = $urandom_range(0, 1) == 1;
            access(st, byt, 1'($urandom), 9'($urandom_range(0, 63)), 16'($urandom), 1);
        end

        check("never_both_enables", 32'(both_en), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
